// File: rtl/array_alloc_pkg.sv
// array_alloc_pkg
// Shared definitions for the array allocation arbiter slice: operation
// encodings, the arbiter FSM state type, default parameter values and a
// small helper for index widths.
package array_alloc_pkg;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_NARRAYS    = 2000;
  localparam int unsigned DEF_MEM_ELEM_W = 12;

  localparam logic OP_ALLOC = 1'b0;
  localparam logic OP_FREE  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  // Bits needed to index n entries (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_alloc_arbiter_if.sv
// array_alloc_arbiter_if
// Requester-side bus of the array allocation arbiter.
//   req/op/free_id         : per-requester request, operation, id to free
//   ack                    : per-requester one-cycle completion pulse
//   rsp_id/rsp_err         : response, valid with any ack bit
//   size_clr/size_clr_id   : pulse to zero the size of a freshly allocated id
//   in_use                 : number of arrays currently allocated
// Modports: master = requesters, slave = arbiter.
interface array_alloc_arbiter_if
  import array_alloc_pkg::*;
#(
  parameter int unsigned NReq               = DEF_NREQ,
  parameter int unsigned MemoryElementWidth = DEF_MEM_ELEM_W
);

  logic [NReq-1:0]                    req;
  logic [NReq-1:0]                    op;
  logic [NReq*MemoryElementWidth-1:0] free_id;
  logic [NReq-1:0]                    ack;
  logic [MemoryElementWidth-1:0]      rsp_id;
  logic                               rsp_err;
  logic                               size_clr;
  logic [MemoryElementWidth-1:0]      size_clr_id;
  logic [MemoryElementWidth:0]        in_use;

  modport master (
    output req, op, free_id,
    input  ack, rsp_id, rsp_err, size_clr, size_clr_id, in_use
  );

  modport slave (
    input  req, op, free_id,
    output ack, rsp_id, rsp_err, size_clr, size_clr_id, in_use
  );

endinterface

// File: rtl/array_free_stack.sv
// array_free_stack
// LIFO of freed array ids (NArrays x MemoryElementWidth storage).
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   push, push_id  : store push_id on top (ignored when full)
//   pop            : discard the top entry (ignored when empty)
//   top            : current top entry, meaningful only when !empty
//   empty, full    : occupancy flags
// Reset clears only the stack pointer; stored ids are left as they are.
module array_free_stack
  import array_alloc_pkg::*;
#(
  parameter int unsigned NArrays            = DEF_NARRAYS,
  parameter int unsigned MemoryElementWidth = DEF_MEM_ELEM_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [MemoryElementWidth-1:0] push_id,
  input  logic                          pop,
  output logic [MemoryElementWidth-1:0] top,
  output logic                          empty,
  output logic                          full
);

  localparam int unsigned IdxW = ptr_w(NArrays);
  localparam int unsigned SpW  = $clog2(NArrays + 1);

  logic [MemoryElementWidth-1:0] mem_q [NArrays];
  logic [SpW-1:0]                sp_q, sp_d;
  logic [IdxW-1:0]               wr_idx, rd_idx;
  logic                          do_push, do_pop;

  always_comb begin
    empty   = (sp_q == '0);
    full    = (sp_q == SpW'(NArrays));
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_idx  = IdxW'(sp_q);
    rd_idx  = IdxW'(sp_q - SpW'(1));
    top     = mem_q[rd_idx];
    sp_d    = sp_q;
    if (do_push) begin
      sp_d = sp_q + SpW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_idx] <= push_id;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

endmodule

// File: rtl/array_alloc_arbiter.sv
// array_alloc_arbiter
// Round-robin arbiter in front of a heap-array id allocator. One request is
// granted per transaction (IDLE -> SERVE -> ACK). Alloc reuses the most
// recently freed id first, otherwise hands out the next never-used id; free
// pushes the id back onto the free stack.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset (aborts an open transaction)
//   bus     : array_alloc_arbiter_if.slave (req/op/free_id in;
//             ack/rsp_id/rsp_err/size_clr/size_clr_id/in_use out)
// Optional build macro ARRAY_ALLOC_DOUBLE_FREE_EN: keeps a per-array live
// mask so freeing an id that is not allocated is reported as an error.
module array_alloc_arbiter
  import array_alloc_pkg::*;
#(
  parameter int unsigned NReq               = DEF_NREQ,
  parameter int unsigned NArrays            = DEF_NARRAYS,
  parameter int unsigned MemoryElementWidth = DEF_MEM_ELEM_W
) (
  input logic                  clock,
  input logic                  reset_n,
  array_alloc_arbiter_if.slave bus
);

  localparam int unsigned PtrW = ptr_w(NReq);
  localparam int unsigned CntW = MemoryElementWidth + 1;
  localparam logic [CntW-1:0] NArraysC = CntW'(NArrays);
  localparam logic [PtrW-1:0] LastReq  = PtrW'(NReq - 1);

  arb_state_e                    state_q, state_d;
  logic [PtrW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]               win_q, win_d;
  logic                          op_q, op_d;
  logic [MemoryElementWidth-1:0] id_q, id_d;
  logic [CntW-1:0]               allocs_q, allocs_d;
  logic [CntW-1:0]               in_use_q, in_use_d;
  logic [NReq-1:0]               ack_q, ack_d;
  logic [MemoryElementWidth-1:0] rsp_id_q, rsp_id_d;
  logic                          rsp_err_q, rsp_err_d;
  logic                          size_clr_q, size_clr_d;
  logic [MemoryElementWidth-1:0] size_clr_id_q, size_clr_id_d;

  // Round-robin pick
  logic                          found;
  logic [PtrW-1:0]               pick;
  logic [PtrW-1:0]               cand;
  logic [MemoryElementWidth-1:0] pick_id;

  // Serve-stage scratch
  logic                          alloc_ok;
  logic                          free_ok;
  logic [MemoryElementWidth-1:0] new_id;

  // Free stack
  logic                          stk_push, stk_pop, stk_empty, stk_full;
  logic [MemoryElementWidth-1:0] stk_top;

`ifdef ARRAY_ALLOC_DOUBLE_FREE_EN
  localparam int unsigned IdxW = ptr_w(NArrays);
  logic [NArrays-1:0] live_q, live_d;
`endif

  array_free_stack #(
    .NArrays            (NArrays),
    .MemoryElementWidth (MemoryElementWidth)
  ) u_free_stack (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (stk_push),
    .push_id (id_q),
    .pop     (stk_pop),
    .top     (stk_top),
    .empty   (stk_empty),
    .full    (stk_full)
  );

  // First asserted request at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    cand    = '0;
    pick_id = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      cand = PtrW'((32'(rr_ptr_q) + i) % NReq);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int unsigned i = 0; i < NReq; i++) begin
      if (PtrW'(i) == pick) begin
        pick_id = bus.free_id[i*MemoryElementWidth +: MemoryElementWidth];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    win_d         = win_q;
    op_d          = op_q;
    id_d          = id_q;
    allocs_d      = allocs_q;
    in_use_d      = in_use_q;
    ack_d         = '0;
    rsp_id_d      = rsp_id_q;
    rsp_err_d     = rsp_err_q;
    size_clr_d    = 1'b0;
    size_clr_id_d = size_clr_id_q;
    stk_pop       = 1'b0;
    stk_push      = 1'b0;
    alloc_ok      = 1'b0;
    free_ok       = 1'b0;
    new_id        = '0;
`ifdef ARRAY_ALLOC_DOUBLE_FREE_EN
    live_d        = live_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          win_d    = pick;
          op_d     = bus.op[pick];
          id_d     = pick_id;
          rr_ptr_d = (pick == LastReq) ? '0 : pick + PtrW'(1);
          state_d  = ST_SERVE;
        end
      end

      ST_SERVE: begin
        state_d      = ST_ACK;
        ack_d[win_q] = 1'b1;
        if (op_q == OP_ALLOC) begin
          // Recycled ids take priority over fresh ones.
          if (!stk_empty) begin
            new_id   = stk_top;
            stk_pop  = 1'b1;
            alloc_ok = 1'b1;
          end else if (allocs_q < NArraysC) begin
            new_id   = allocs_q[MemoryElementWidth-1:0];
            allocs_d = allocs_q + CntW'(1);
            alloc_ok = 1'b1;
          end
          if (alloc_ok) begin
            rsp_id_d      = new_id;
            rsp_err_d     = 1'b0;
            size_clr_d    = 1'b1;
            size_clr_id_d = new_id;
            in_use_d      = in_use_q + CntW'(1);
`ifdef ARRAY_ALLOC_DOUBLE_FREE_EN
            live_d[new_id[IdxW-1:0]] = 1'b1;
`endif
          end else begin
            rsp_id_d  = '0;
            rsp_err_d = 1'b1;
          end
        end else begin
          // A full stack can only arise from unchecked duplicate frees;
          // refusing the push keeps the stack pointer in range.
          free_ok = ({1'b0, id_q} < allocs_q) && !stk_full;
`ifdef ARRAY_ALLOC_DOUBLE_FREE_EN
          free_ok = free_ok && live_q[id_q[IdxW-1:0]];
`endif
          rsp_id_d  = '0;
          rsp_err_d = !free_ok;
          if (free_ok) begin
            stk_push = 1'b1;
            in_use_d = (in_use_q != '0) ? in_use_q - CntW'(1) : '0;
`ifdef ARRAY_ALLOC_DOUBLE_FREE_EN
            live_d[id_q[IdxW-1:0]] = 1'b0;
`endif
          end
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      win_q         <= '0;
      op_q          <= OP_ALLOC;
      id_q          <= '0;
      allocs_q      <= '0;
      in_use_q      <= '0;
      ack_q         <= '0;
      rsp_id_q      <= '0;
      rsp_err_q     <= 1'b0;
      size_clr_q    <= 1'b0;
      size_clr_id_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      win_q         <= win_d;
      op_q          <= op_d;
      id_q          <= id_d;
      allocs_q      <= allocs_d;
      in_use_q      <= in_use_d;
      ack_q         <= ack_d;
      rsp_id_q      <= rsp_id_d;
      rsp_err_q     <= rsp_err_d;
      size_clr_q    <= size_clr_d;
      size_clr_id_q <= size_clr_id_d;
    end
  end

`ifdef ARRAY_ALLOC_DOUBLE_FREE_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      live_q <= '0;
    end else begin
      live_q <= live_d;
    end
  end
`endif

  assign bus.ack         = ack_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.size_clr    = size_clr_q;
  assign bus.size_clr_id = size_clr_id_q;
  assign bus.in_use      = in_use_q;

endmodule

// File: tb/tb_array_alloc_arbiter.sv
// tb_array_alloc_arbiter
// Scoreboard bench for array_alloc_arbiter (NReq=4, NArrays=4, 12-bit ids).
// Stimulus pushes expected acks and state probes into queues; a negedge
// monitor pops and compares. Build with ARRAY_ALLOC_DOUBLE_FREE_EN to
// exercise the live-mask variant.
module tb_array_alloc_arbiter;
  import array_alloc_pkg::*;

  localparam int NR = 4;
  localparam int MW = 12;

  typedef struct {
    int tag;
    int idx;
    int id;
    int err;
    int in_use;
    int clr;
    int cyc;
  } exp_t;

  localparam int P_STATE   = 0;
  localparam int P_TIMEOUT = 1;
  localparam int P_DRAIN   = 2;

  typedef struct {
    int    kind;
    string name;
    int    val;
  } probe_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   base_cyc = 0;
  int   batch_n = 0;
  int   tag_n = 0;

  exp_t   exp_q[$];
  probe_t probe_q[$];
  exp_t   e;
  probe_t p;

  array_alloc_arbiter_if #(.NReq(NR), .MemoryElementWidth(MW)) bus ();

  array_alloc_arbiter #(
    .NReq               (NR),
    .NArrays            (4),
    .MemoryElementWidth (MW)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int tag, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s #%0d: actual %0d required %0d", name, tag, act, expv);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    if (bus.ack != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", -1, int'(bus.ack), 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_onehot", e.tag, int'(bus.ack), 1 << e.idx);
        chk("rsp_id", e.tag, int'(bus.rsp_id), e.id);
        chk("rsp_err", e.tag, int'(bus.rsp_err), e.err);
        chk("in_use", e.tag, int'(bus.in_use), e.in_use);
        chk("size_clr", e.tag, int'(bus.size_clr), e.clr);
        if (e.clr != 0) chk("size_clr_id", e.tag, int'(bus.size_clr_id), e.id);
        chk("ack_cycle", e.tag, cyc, e.cyc);
      end
    end
    if (probe_q.size() != 0) begin
      p = probe_q.pop_front();
      case (p.kind)
        P_STATE: begin
          chk({p.name, "_ack"}, 0, int'(bus.ack), 0);
          chk({p.name, "_in_use"}, 0, int'(bus.in_use), p.val);
          chk({p.name, "_rsp_id"}, 0, int'(bus.rsp_id), 0);
          chk({p.name, "_rsp_err"}, 0, int'(bus.rsp_err), 0);
          chk({p.name, "_size_clr"}, 0, int'(bus.size_clr), 0);
          chk({p.name, "_size_clr_id"}, 0, int'(bus.size_clr_id), 0);
        end
        P_TIMEOUT: chk({p.name, "_pending_req"}, 0, p.val, 0);
        default:   chk("scoreboard_drain", 0, exp_q.size(), 0);
      endcase
    end
  end

  task automatic begin_batch();
    @(negedge clk);
    base_cyc = cyc;
    batch_n  = 0;
  endtask

  // k-th grant of a batch: sampled at base+1+3k, ack seen in cycle base+2+3k.
  task automatic expect_ack(input int idx, input int id, input int err,
                            input int in_use, input int clr);
    exp_t x;
    x.tag    = tag_n;
    x.idx    = idx;
    x.id     = id;
    x.err    = err;
    x.in_use = in_use;
    x.clr    = clr;
    x.cyc    = base_cyc + 2 + 3 * batch_n;
    exp_q.push_back(x);
    batch_n++;
    tag_n++;
  endtask

  task automatic set_req(input int i, input logic o, input int id);
    logic [1:0] s;
    s = 2'(i);
    bus.op[s] = o;
    bus.free_id[int'(s)*MW +: MW] = MW'(id);
  endtask

  task automatic run(input logic [NR-1:0] mask, input string name);
    probe_t t;
    bus.req = mask;
    for (int c = 0; c < 60 && bus.req != '0; c++) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.ack;
    end
    if (bus.req != '0) begin
      t.kind = P_TIMEOUT;
      t.name = name;
      t.val  = int'(bus.req);
      probe_q.push_back(t);
      bus.req = '0;
    end
  endtask

  task automatic single(input int i, input logic o, input int id, input int eid,
                        input int eerr, input int einuse, input int eclr);
    begin_batch();
    set_req(i, o, id);
    expect_ack(i, eid, eerr, einuse, eclr);
    run(NR'(1) << i, "single");
  endtask

  task automatic push_probe(input int kind, input string name, input int val);
    probe_t t;
    @(posedge clk);
    #1;
    t.kind = kind;
    t.name = name;
    t.val  = val;
    probe_q.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.op      = '0;
    bus.free_id = '0;
    do_reset();
    push_probe(P_STATE, "reset", 0);

    // Three allocs from requester 0: fresh ids 0,1,2.
    single(0, OP_ALLOC, 0, 0, 0, 1, 1);
    single(0, OP_ALLOC, 0, 1, 0, 2, 1);
    single(0, OP_ALLOC, 0, 2, 0, 3, 1);

    // Free then alloc returns the freed id.
    single(0, OP_FREE, 1, 0, 0, 2, 0);
    single(0, OP_ALLOC, 0, 1, 0, 3, 1);

    // Free of an id never handed out (allocs=3).
    single(2, OP_FREE, 7, 0, 1, 3, 0);

    // Double free of id 1.
    single(1, OP_FREE, 1, 0, 0, 2, 0);
`ifdef ARRAY_ALLOC_DOUBLE_FREE_EN
    single(1, OP_FREE, 1, 0, 1, 2, 0);
`else
    single(1, OP_FREE, 1, 0, 0, 1, 0);
`endif

    // Four simultaneous allocs after reset: grants 0,1,2,3 with ids 0..3.
    do_reset();
    begin_batch();
    for (int i = 0; i < NR; i++) set_req(i, OP_ALLOC, 0);
    for (int i = 0; i < NR; i++) expect_ack(i, i, 0, i + 1, 1);
    run(4'b1111, "all_alloc");

    // Fifth alloc with NArrays=4 exhausted.
    single(1, OP_ALLOC, 0, 0, 1, 4, 0);

    // rr_ptr is now 2: requester 2 (frees 3) goes before requester 1 (frees 2).
    begin_batch();
    set_req(1, OP_FREE, 2);
    set_req(2, OP_FREE, 3);
    expect_ack(2, 0, 0, 3, 0);
    expect_ack(1, 0, 0, 2, 0);
    run(4'b0110, "rr_wrap");

    // LIFO: last freed id (2) comes back first.
    single(0, OP_ALLOC, 0, 2, 0, 3, 1);

    // Reset while the arbiter is in SERVE: no ack, counters cleared.
    begin_batch();
    set_req(0, OP_ALLOC, 0);
    bus.req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push_probe(P_STATE, "abort", 0);
    single(0, OP_ALLOC, 0, 0, 0, 1, 1);

    repeat (3) @(negedge clk);
    push_probe(P_DRAIN, "drain", 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
